request_encoder: RTL and testbench
==================================

Name: request_encoder

Overview:
- Sequential encoder: the inverse of the team's one-hot address decoder.
- Accepts a WIDTH-bit request vector over a valid/ready handshake and serializes it into a stream of {address, enable} beats, one per set bit, lowest index first.
- Feeding every beat into the decoder and ORing its outputs reproduces the original vector.
- Sits between request sources (interrupt lines, bank-select flags) and decoder-driven select logic.

Parameters:
- WIDTH, 4, request vector width; must be a power of two, at least 2.
- ADDR_W, clog2(WIDTH) = 2, address width; derived, must not be overridden.

Ports:
- clk  input  1  single clock; all state updates on its rising edge.
- reset  input  1  asynchronous, active-high; clears all state immediately.
- in_valid  input  1  requests vector is presented.
- in_ready  output  1  block can accept a vector this cycle.
- requests  input  WIDTH  request vector; bit i requests address i.
- out_valid  output  1  beat is presented.
- out_ready  input  1  consumer accepts the beat.
- address  output  ADDR_W  encoded index of the current request bit.
- enable  output  1  1 = address is a real request; 0 = empty-vector beat.
- last  output  1  final beat of the current vector.

Behaviour:
- Reset values: state=IDLE, pending=0, out_valid=0, address=0, enable=0, last=0.
  - in_ready follows state and reads 1 during reset, but no capture occurs while reset is high.
  - Reset mid-burst drops the remaining bits with no further beats.
- States:
  - IDLE: no vector held.
  - EMIT: a beat is registered on the outputs.
- Handshakes:
  - Input transfer when in_valid and in_ready are both high at a rising edge.
  - Output transfer when out_valid and out_ready are both high at a rising edge.
- in_ready = (state==IDLE) or (out_valid and out_ready and last). This is combinational from out_ready, giving zero-bubble back-to-back vectors.
- Capture (IDLE or last handshake, with in_valid):
  - pending <= requests.
  - The first beat is registered at the same edge: out_valid=1 from the next cycle. Latency is 1 cycle.
- Beat contents, with p = the pending vector the beat is drawn from:
  - Non-zero p: address = index of the lowest set bit of p; enable=1; last=1 iff p has exactly one bit set.
  - Zero vector: exactly one beat with address=0, enable=0, last=1.
- On a non-last output handshake:
  - Clear the emitted bit from pending.
  - Register the next beat from the updated pending at the same edge.
  - No idle cycle between beats.
- On a last handshake:
  - With in_valid high: capture the new vector at the same edge (stay in EMIT).
  - Otherwise: go to IDLE and set out_valid=0.
- Stall: while out_valid and not out_ready, address, enable, last and pending hold stable. The requests input is ignored outside capture.
- A vector of N set bits produces exactly N beats in N cycles under continuous out_ready. An all-ones vector yields addresses 0..WIDTH-1 in order.
- Outputs are registered (glitch-free); only in_ready is combinational.

Decomposition:
- Shared package holds:
  - state encoding (IDLE=0, EMIT=1);
  - a clog2 constant function;
  - the empty-beat constants (address 0, enable 0).
- One natural sub-module, lowest_set_finder (combinational):
  - inputs: WIDTH-bit vector;
  - outputs: ADDR_W index, any-set flag, exactly-one-set flag.
  - The top level reuses it for both the capture path and the advance path.

Test Plan:
- Reset, then requests=4'b1010 with in_valid for one cycle, out_ready=1 -> beats (address=1,enable=1,last=0) then (3,1,1); in_ready=1 again in the cycle of the last beat.
- requests=4'b0000 -> single beat address=0, enable=0, last=1; no further beats.
- requests=4'b1111 with out_ready toggling 1,0,0,1,1,1 -> addresses 0,1,2,3 in order; outputs held constant during the stall cycles; last only on address 3.
- Back-to-back: 4'b0100 then 4'b0001 with in_valid held, out_ready=1 -> beats (2,1,1) and (0,1,1) on consecutive cycles, no bubble.
- Assert reset mid-burst of 4'b1110 after the first beat -> out_valid=0 immediately (asynchronous); after release, in_ready=1 and no stale beats appear.
- Scoreboard random vectors through request_encoder into the decoder -> OR of decoder outputs per vector equals the input vector; beat count equals popcount (or 1 for zero).

Source files
------------

// File: rtl/request_encoder_pkg.sv
// request_encoder_pkg: shared state encoding, clog2 helper and empty-beat constants
package request_encoder_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      EMIT = 1'b1
   } state_t;

   localparam int   EMPTY_ADDR = 0;
   localparam logic EMPTY_EN   = 1'b0;

   function automatic int clog2(input int v);
      int r;
      r = 0;
      while ((1 << r) < v) r++;
      return r;
   endfunction

endpackage

// File: rtl/request_encoder_lsf.sv
// lowest_set_finder: index of the lowest set bit, plus any-set and exactly-one-set flags
module lowest_set_finder #(
   parameter int WIDTH  = 4,
   parameter int ADDR_W = 2
) (
   input  logic [WIDTH-1:0]  vec,
   output logic [ADDR_W-1:0] idx,
   output logic              any,
   output logic              one
);

   always_comb begin
      idx = '0;
      for (int i = WIDTH - 1; i >= 0; i--)
         if (vec[i]) idx = ADDR_W'(i);
   end

   assign any = |vec;
   assign one = any && ((vec & (vec - WIDTH'(1))) == '0);

endmodule

// File: rtl/request_encoder.sv
// request_encoder: serializes a request vector into {address, enable} beats, lowest set bit first
module request_encoder
   import request_encoder_pkg::*;
#(
   parameter  int WIDTH  = 4,
   localparam int ADDR_W = clog2(WIDTH)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [WIDTH-1:0]  requests,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [ADDR_W-1:0] address,
   output logic              enable,
   output logic              last
);

   state_t             state, state_n;
   logic [WIDTH-1:0]   pending, pending_n, cleared;
   logic               valid_n, en_n, last_n;
   logic [ADDR_W-1:0]  addr_n, cap_idx, adv_idx;
   logic               cap_any, cap_one, adv_any, adv_one;
   logic               fire, capture, advance;

   // clearing the lowest set bit is the same as clearing the bit just emitted
   assign cleared  = pending & (pending - WIDTH'(1));
   assign fire     = out_valid && out_ready;
   assign in_ready = (state == IDLE) || (fire && last);
   assign capture  = in_valid && in_ready;
   assign advance  = fire && !last;

   lowest_set_finder #(.WIDTH(WIDTH), .ADDR_W(ADDR_W)) u_cap (
      .vec(requests), .idx(cap_idx), .any(cap_any), .one(cap_one)
   );

   lowest_set_finder #(.WIDTH(WIDTH), .ADDR_W(ADDR_W)) u_adv (
      .vec(cleared), .idx(adv_idx), .any(adv_any), .one(adv_one)
   );

   always_comb begin
      state_n   = state;
      pending_n = pending;
      valid_n   = out_valid;
      addr_n    = address;
      en_n      = enable;
      last_n    = last;
      if (capture) begin
         state_n   = EMIT;
         pending_n = requests;
         valid_n   = 1'b1;
         addr_n    = cap_any ? cap_idx : ADDR_W'(EMPTY_ADDR);
         en_n      = cap_any ? 1'b1 : EMPTY_EN;
         last_n    = !cap_any || cap_one;
      end else if (advance) begin
         pending_n = cleared;
         addr_n    = adv_any ? adv_idx : ADDR_W'(EMPTY_ADDR);
         en_n      = adv_any;
         last_n    = !adv_any || adv_one;
      end else if (fire) begin
         state_n = IDLE;
         valid_n = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= IDLE;
         pending   <= '0;
         out_valid <= 1'b0;
         address   <= '0;
         enable    <= 1'b0;
         last      <= 1'b0;
      end else begin
         state     <= state_n;
         pending   <= pending_n;
         out_valid <= valid_n;
         address   <= addr_n;
         enable    <= en_n;
         last      <= last_n;
      end
   end

endmodule

// File: tb/tb_request_encoder.sv
// tb_request_encoder: scenario tasks plus a randomized decode-and-OR scoreboard for request_encoder
module tb_request_encoder;

   localparam int WIDTH  = 4;
   localparam int ADDR_W = 2;

   logic              clk = 1'b0;
   logic              reset = 1'b1;
   logic              in_valid = 1'b0;
   logic              in_ready;
   logic [WIDTH-1:0]  requests = '0;
   logic              out_valid;
   logic              out_ready = 1'b0;
   logic [ADDR_W-1:0] address;
   logic              enable;
   logic              last;

   int vectors = 0;
   int miscompares = 0;

   request_encoder #(.WIDTH(WIDTH)) dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
      .requests(requests), .out_valid(out_valid), .out_ready(out_ready),
      .address(address), .enable(enable), .last(last)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      step();
      step();
      vectors++;
      if ({out_valid, address, enable, last, in_ready} !== {1'b0, 2'd0, 1'b0, 1'b0, 1'b1}) begin
         miscompares++;
         $display("FAIL reset: got v=%b a=%0d e=%b l=%b r=%b, want v=0 a=0 e=0 l=0 r=1",
                  out_valid, address, enable, last, in_ready);
      end
      reset = 1'b0;
      step();
   endtask

   task automatic test_basic();
      requests = 4'b1010; in_valid = 1'b1; out_ready = 1'b1;
      #1;
      vectors++;
      if (in_ready !== 1'b1) begin miscompares++; $display("FAIL basic_ready0: got %b want 1", in_ready); end
      step();
      in_valid = 1'b0; requests = 4'b0110;
      #1;
      vectors++;
      if ({out_valid, address, enable, last, in_ready} !== {1'b1, 2'd1, 1'b1, 1'b0, 1'b0}) begin
         miscompares++;
         $display("FAIL basic_beat0: got v=%b a=%0d e=%b l=%b r=%b, want 1 1 1 0 0", out_valid, address, enable, last, in_ready);
      end
      step();
      vectors++;
      if ({out_valid, address, enable, last, in_ready} !== {1'b1, 2'd3, 1'b1, 1'b1, 1'b1}) begin
         miscompares++;
         $display("FAIL basic_beat1: got v=%b a=%0d e=%b l=%b r=%b, want 1 3 1 1 1", out_valid, address, enable, last, in_ready);
      end
      step();
      vectors++;
      if (out_valid !== 1'b0) begin miscompares++; $display("FAIL basic_idle: got out_valid=%b want 0", out_valid); end
   endtask

   task automatic test_zero();
      requests = 4'b0000; in_valid = 1'b1; out_ready = 1'b1;
      step();
      in_valid = 1'b0;
      #1;
      vectors++;
      if ({out_valid, address, enable, last} !== {1'b1, 2'd0, 1'b0, 1'b1}) begin
         miscompares++;
         $display("FAIL zero_beat: got v=%b a=%0d e=%b l=%b, want 1 0 0 1", out_valid, address, enable, last);
      end
      for (int k = 0; k < 3; k++) begin
         step();
         vectors++;
         if (out_valid !== 1'b0) begin miscompares++; $display("FAIL zero_extra: got out_valid=%b want 0 (cycle %0d)", out_valid, k); end
      end
   endtask

   task automatic test_stall();
      bit pat [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
      int idx = 0;
      requests = 4'b1111; in_valid = 1'b1; out_ready = 1'b1;
      step();
      in_valid = 1'b0;
      for (int k = 0; k < 6; k++) begin
         out_ready = pat[k];
         #1;
         vectors++;
         if ({out_valid, address, enable, last} !== {1'b1, 2'(idx), 1'b1, idx == 3}) begin
            miscompares++;
            $display("FAIL stall_beat%0d: got v=%b a=%0d e=%b l=%b, want 1 %0d 1 %0d",
                     k, out_valid, address, enable, last, idx, idx == 3);
         end
         step();
         if (pat[k]) idx++;
      end
      vectors++;
      if ({out_valid, 3'(idx)} !== {1'b0, 3'd4}) begin
         miscompares++;
         $display("FAIL stall_end: got v=%b beats=%0d want v=0 beats=4", out_valid, idx);
      end
      out_ready = 1'b1;
   endtask

   task automatic test_back_to_back();
      requests = 4'b0100; in_valid = 1'b1; out_ready = 1'b1;
      step();
      requests = 4'b0001;
      #1;
      vectors++;
      if ({out_valid, address, enable, last, in_ready} !== {1'b1, 2'd2, 1'b1, 1'b1, 1'b1}) begin
         miscompares++;
         $display("FAIL b2b_first: got v=%b a=%0d e=%b l=%b r=%b, want 1 2 1 1 1", out_valid, address, enable, last, in_ready);
      end
      step();
      in_valid = 1'b0;
      #1;
      vectors++;
      if ({out_valid, address, enable, last} !== {1'b1, 2'd0, 1'b1, 1'b1}) begin
         miscompares++;
         $display("FAIL b2b_second: got v=%b a=%0d e=%b l=%b, want 1 0 1 1", out_valid, address, enable, last);
      end
      step();
      vectors++;
      if (out_valid !== 1'b0) begin miscompares++; $display("FAIL b2b_idle: got out_valid=%b want 0", out_valid); end
   endtask

   task automatic test_reset_mid();
      requests = 4'b1110; in_valid = 1'b1; out_ready = 1'b1;
      step();
      in_valid = 1'b0;
      step();
      vectors++;
      if ({out_valid, address} !== {1'b1, 2'd2}) begin
         miscompares++;
         $display("FAIL rmid_pre: got v=%b a=%0d want 1 2", out_valid, address);
      end
      reset = 1'b1;
      #1;
      vectors++;
      if ({out_valid, enable, last, in_ready} !== {1'b0, 1'b0, 1'b0, 1'b1}) begin
         miscompares++;
         $display("FAIL rmid_async: got v=%b e=%b l=%b r=%b want 0 0 0 1", out_valid, enable, last, in_ready);
      end
      step();
      reset = 1'b0;
      for (int k = 0; k < 3; k++) begin
         step();
         vectors++;
         if ({out_valid, in_ready} !== {1'b0, 1'b1}) begin
            miscompares++;
            $display("FAIL rmid_stale: got v=%b r=%b want 0 1 (cycle %0d)", out_valid, in_ready, k);
         end
      end
   endtask

   task automatic test_random();
      for (int n = 0; n < 60; n++) begin
         logic [WIDTH-1:0] v, or_vec;
         int exp_addr[$];
         int beats, expect_beats;
         bit done;
         v = WIDTH'($urandom);
         if (n == 0) v = '1;
         if (n == 1) v = '0;
         exp_addr.delete();
         for (int i = 0; i < WIDTH; i++) if (v[i]) exp_addr.push_back(i);
         expect_beats = (exp_addr.size() == 0) ? 1 : exp_addr.size();
         requests = v; in_valid = 1'b1; out_ready = 1'b0;
         step();
         in_valid = 1'b0; requests = WIDTH'($urandom);
         or_vec = '0; beats = 0; done = 1'b0;
         for (int c = 0; c < 50 && !done; c++) begin
            out_ready = ($urandom_range(0, 3) != 0);
            #1;
            if (out_valid && out_ready) begin
               logic [ADDR_W-1:0] ea;
               logic ee, el;
               ea = (exp_addr.size() == 0) ? 2'd0 : 2'(exp_addr[beats < exp_addr.size() ? beats : 0]);
               ee = (exp_addr.size() != 0);
               el = (beats == expect_beats - 1);
               vectors++;
               if ({address, enable, last} !== {ea, ee, el}) begin
                  miscompares++;
                  $display("FAIL rand_beat v=%b #%0d: got a=%0d e=%b l=%b want a=%0d e=%b l=%b",
                           v, beats, address, enable, last, ea, ee, el);
               end
               if (enable) or_vec |= WIDTH'(1) << address;
               beats++;
               if (last) done = 1'b1;
            end
            step();
         end
         vectors++;
         if ({done, or_vec, beats} !== {1'b1, v, expect_beats}) begin
            miscompares++;
            $display("FAIL rand_vec: got done=%b or=%b beats=%0d want done=1 or=%b beats=%0d",
                     done, or_vec, beats, v, expect_beats);
         end
         vectors++;
         if (out_valid !== 1'b0) begin miscompares++; $display("FAIL rand_idle: got out_valid=%b want 0", out_valid); end
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_zero();
      test_stall();
      test_back_to_back();
      test_reset_mid();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
